// File: rtl/matrix_op_engine.sv
// Element-serial 5x5 matrix engine: ADD/SUB/MUL/TRANSPOSE/SCALAR/CONV on latched operands
// through one shared 9x9 multiplier and 21-bit accumulator, with saturated signed 8-bit results.
module matrix_op_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op_code,
  input  logic [1:0]   matrix_size,
  input  logic [199:0] pixel_data,
  input  logic [199:0] kernel_data,
  output logic [199:0] result_final,
  output logic         process_Done,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  localparam logic [2:0] OpAdd    = 3'd0;
  localparam logic [2:0] OpSub    = 3'd1;
  localparam logic [2:0] OpMul    = 3'd2;
  localparam logic [2:0] OpTrans  = 3'd3;
  localparam logic [2:0] OpScalar = 3'd4;
  localparam logic [2:0] OpConv   = 3'd5;

  state_e state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          size_q, size_d;
  logic [199:0]        a_q, a_d, b_q, b_d;
  logic [2:0]          r_q, r_d, c_q, c_d, k_q, k_d;
  logic signed [20:0]  acc_q, acc_d;
  logic [199:0]        buf_q, buf_d, result_q, result_d;
  logic                done_q, done_d, busy_q, busy_d;

  logic [2:0]          nm1;
  logic                last_r, last_c, last_k, step_last;
  logic [4:0]          idx_rc, a_idx, b_idx, wr_idx;
  logic [7:0]          a_byte, b_byte;
  logic signed [17:0]  opa_x, opb_x, prod;
  logic signed [20:0]  opa_w, opb_w, prod_w, value;
  logic                wr_en;

  function automatic logic [4:0] idx_of(input logic [2:0] r, input logic [2:0] c);
    logic [4:0] rr;
    rr = {2'b00, r};
    return (rr << 2) + rr + {2'b00, c};
  endfunction

  function automatic logic [7:0] sat8(input logic signed [20:0] v);
    if (v > 21'sd127) begin
      return 8'h7f;
    end else if (v < -21'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

  assign nm1    = {1'b0, size_q} + 3'd1;
  assign last_r = (r_q == nm1);
  assign last_c = (c_q == nm1);
  assign last_k = (k_q == nm1);
  assign idx_rc = idx_of(r_q, c_q);

  // Reserved opcodes take a single dummy step.
  assign step_last = (op_q == OpMul)     ? (last_k & last_c & last_r) :
                     (op_q[2:1] == 2'b11) ? 1'b1 : (last_c & last_r);

  always_comb begin
    a_idx = idx_rc;
    b_idx = idx_rc;
    case (op_q)
      OpMul: begin
        a_idx = idx_of(r_q, k_q);
        b_idx = idx_of(k_q, c_q);
      end
      OpTrans:  a_idx = idx_of(c_q, r_q);
      OpScalar: b_idx = 5'd0;
      default: ;
    endcase
  end

  assign a_byte = a_q[{a_idx, 3'b000} +: 8];
  assign b_byte = b_q[{b_idx, 3'b000} +: 8];
  assign opa_x  = {10'b0, a_byte};
  assign opb_x  = {{10{b_byte[7]}}, b_byte};
  assign prod   = opa_x * opb_x;
  assign opa_w  = {13'b0, a_byte};
  assign opb_w  = {{13{b_byte[7]}}, b_byte};
  assign prod_w = {{3{prod[17]}}, prod};

  // State register (plus all datapath registers)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      size_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      buf_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      size_q   <= size_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      buf_q    <= buf_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCompute;
      StCompute: if (step_last) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    op_d     = op_q;
    size_d   = size_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    c_d      = c_q;
    k_d      = k_q;
    acc_d    = acc_q;
    buf_d    = buf_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    value    = '0;
    wr_en    = 1'b0;
    wr_idx   = idx_rc;
    unique case (state_q)
      StIdle: begin
        // busy stays up through the cycle after the done pulse, then follows acceptance
        busy_d = start;
        if (start) begin
          op_d   = op_code;
          size_d = matrix_size;
          a_d    = pixel_data;
          b_d    = kernel_data;
          r_d    = '0;
          c_d    = '0;
          k_d    = '0;
          acc_d  = '0;
          buf_d  = '0;
        end
      end
      StCompute: begin
        busy_d = 1'b1;
        case (op_q)
          OpAdd: begin
            value = opa_w + opb_w;
            wr_en = 1'b1;
          end
          OpSub: begin
            value = opa_w - opb_w;
            wr_en = 1'b1;
          end
          OpMul: begin
            value = acc_q + prod_w;
            acc_d = last_k ? '0 : value;
            wr_en = last_k;
          end
          OpTrans: begin
            value = opa_w;
            wr_en = 1'b1;
          end
          OpScalar: begin
            value = prod_w;
            wr_en = 1'b1;
          end
          OpConv: begin
            value  = acc_q + prod_w;
            acc_d  = value;
            wr_en  = step_last;
            wr_idx = 5'd0;
          end
          default: ;
        endcase
        if (wr_en) buf_d[{wr_idx, 3'b000} +: 8] = sat8(value);
        if ((op_q == OpMul) && !last_k) begin
          k_d = k_q + 3'd1;
        end else begin
          k_d = '0;
          if (!last_c) begin
            c_d = c_q + 3'd1;
          end else begin
            c_d = '0;
            r_d = r_q + 3'd1;
          end
        end
      end
      StDone: begin
        busy_d   = 1'b1;
        done_d   = 1'b1;
        result_d = buf_q;
      end
      default: ;
    endcase
  end

  assign result_final = result_q;
  assign process_Done = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_matrix_op_engine.sv
// Directed self-checking bench for matrix_op_engine: arithmetic, saturation, latency,
// result holding, reset abort and start handling.
module tb_matrix_op_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op_code;
  logic [1:0]   matrix_size;
  logic [199:0] pixel_data;
  logic [199:0] kernel_data;
  logic [199:0] result_final;
  logic         process_Done;
  logic         busy;

  int checks = 0;
  int failures = 0;

  matrix_op_engine dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_code      (op_code),
    .matrix_size  (matrix_size),
    .pixel_data   (pixel_data),
    .kernel_data  (kernel_data),
    .result_final (result_final),
    .process_Done (process_Done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Bytes with r,c < n set to v, everything else 0.
  function automatic logic [199:0] grid(input logic [7:0] v, input int n);
    logic [199:0] g;
    g = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) g[(5 * r + c) * 8 +: 8] = v;
    return g;
  endfunction

  // Issues one operation, scrambles inputs after acceptance, returns edges from t0 to done.
  task automatic run_op(input logic [2:0] op, input logic [1:0] sz, input logic [199:0] pix,
                        input logic [199:0] ker, output int lat, output logic busy_ok);
    @(negedge clk);
    op_code = op;
    matrix_size = sz;
    pixel_data = pix;
    kernel_data = ker;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_code = 3'b010;
    matrix_size = 2'b11;
    pixel_data = ~pix;
    kernel_data = ~ker;
    busy_ok = busy;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_ok = 1'b0;
      if (process_Done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op_code = '0;
    matrix_size = '0;
    pixel_data = '0;
    kernel_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (result_final !== '0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0", result_final);
    end
    checks++;
    if (process_Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", process_Done);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_add();
    int lat;
    logic bok;
    run_op(3'b000, 2'b01, grid(8'd10, 5), grid(8'd5, 5), lat, bok);
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL add_latency got=%0d exp=10", lat);
    end
    checks++;
    if (bok !== 1'b1) begin
      failures++;
      $display("FAIL add_busy_high got=%b exp=1", bok);
    end
    checks++;
    if (result_final !== grid(8'd15, 3)) begin
      failures++;
      $display("FAIL add_result got=%h exp=%h", result_final, grid(8'd15, 3));
    end
    @(posedge clk);
    #1;
    checks++;
    if ({process_Done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL add_done_pulse got=%b%b exp=00", process_Done, busy);
    end
  endtask

  task automatic test_sub_sat();
    int lat;
    logic bok;
    logic [199:0] pix, ker, exp;
    pix = '0;
    ker = '0;
    exp = '0;
    pix[7:0] = 8'd200; ker[7:0] = 8'h9c; exp[7:0] = 8'h7f;
    pix[15:8] = 8'd0;  ker[15:8] = 8'h7f; exp[15:8] = 8'h81;
    pix[47:40] = 8'd0; ker[47:40] = 8'h80; exp[47:40] = 8'h7f;
    pix[55:48] = 8'd5; ker[55:48] = 8'h03; exp[55:48] = 8'h02;
    run_op(3'b001, 2'b00, pix, ker, lat, bok);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL sub_latency got=%0d exp=5", lat);
    end
    checks++;
    if (result_final !== exp) begin
      failures++;
      $display("FAIL sub_sat_result got=%h exp=%h", result_final, exp);
    end
  endtask

  task automatic test_mul();
    int lat;
    logic bok;
    logic [199:0] pix, ker, exp;
    pix = '0;
    ker = '0;
    exp = '0;
    pix[7:0] = 8'd1; pix[15:8] = 8'd2; pix[47:40] = 8'd3; pix[55:48] = 8'd4;
    ker[7:0] = 8'd5; ker[15:8] = 8'd6; ker[47:40] = 8'd7; ker[55:48] = 8'd8;
    exp[7:0] = 8'd19; exp[15:8] = 8'd22; exp[47:40] = 8'd43; exp[55:48] = 8'd50;
    run_op(3'b010, 2'b00, pix, ker, lat, bok);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL mul2_latency got=%0d exp=9", lat);
    end
    checks++;
    if (result_final !== exp) begin
      failures++;
      $display("FAIL mul2_result got=%h exp=%h", result_final, exp);
    end
    pix = '0;
    for (int i = 0; i < 5; i++) pix[(6 * i) * 8 +: 8] = 8'd1;
    for (int i = 0; i < 25; i++) ker[i * 8 +: 8] = 8'(i - 12);
    run_op(3'b010, 2'b11, pix, ker, lat, bok);
    checks++;
    if (lat !== 126) begin
      failures++;
      $display("FAIL mul5_latency got=%0d exp=126", lat);
    end
    checks++;
    if (result_final !== ker) begin
      failures++;
      $display("FAIL mul5_identity got=%h exp=%h", result_final, ker);
    end
  endtask

  task automatic test_conv();
    int lat;
    logic bok;
    logic [199:0] exp;
    run_op(3'b101, 2'b11, grid(8'd255, 5), grid(8'd127, 5), lat, bok);
    exp = '0;
    exp[7:0] = 8'h7f;
    checks++;
    if (lat !== 26) begin
      failures++;
      $display("FAIL conv_latency got=%0d exp=26", lat);
    end
    checks++;
    if (result_final !== exp) begin
      failures++;
      $display("FAIL conv_sat got=%h exp=%h", result_final, exp);
    end
    run_op(3'b101, 2'b11, grid(8'd1, 5), grid(8'hff, 5), lat, bok);
    exp[7:0] = 8'he7;
    checks++;
    if (result_final !== exp) begin
      failures++;
      $display("FAIL conv_neg got=%h exp=%h", result_final, exp);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    op_code = 3'b010;
    matrix_size = 2'b11;
    pixel_data = grid(8'd1, 5);
    kernel_data = grid(8'd1, 5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({result_final, process_Done, busy} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got=%h/%b/%b exp=0/0/0", result_final, process_Done, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (process_Done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got=%b exp=0", seen);
    end
  endtask

  task automatic test_transpose_reserved();
    int lat;
    logic bok;
    logic [199:0] pix, exp;
    pix = {25{8'haa}};
    exp = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        pix[(5 * r + c) * 8 +: 8] = 8'(10 * r + c);
        exp[(5 * r + c) * 8 +: 8] = 8'(10 * c + r);
      end
    run_op(3'b011, 2'b10, pix, grid(8'h55, 5), lat, bok);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL trans_latency got=%0d exp=17", lat);
    end
    checks++;
    if (result_final !== exp) begin
      failures++;
      $display("FAIL trans_result got=%h exp=%h", result_final, exp);
    end
    @(negedge clk);
    op_code = 3'b111;
    matrix_size = 2'b11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({result_final, process_Done} !== {exp, 1'b0}) begin
      failures++;
      $display("FAIL rsvd_hold got=%h/%b exp=%h/0", result_final, process_Done, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({result_final, process_Done} !== {200'b0, 1'b1}) begin
      failures++;
      $display("FAIL rsvd_zero got=%h/%b exp=0/1", result_final, process_Done);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    op_code = 3'b000;
    matrix_size = 2'b00;
    pixel_data = grid(8'd3, 5);
    kernel_data = grid(8'd4, 5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      start = (i == 2);
      if (i == 2) op_code = 3'b010;
      @(posedge clk);
      #1;
      if (process_Done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL ign_latency got=%0d exp=5", lat);
    end
    checks++;
    if (result_final !== grid(8'd7, 2)) begin
      failures++;
      $display("FAIL ign_result got=%h exp=%h", result_final, grid(8'd7, 2));
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_busy_after got=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_start_same();
    logic seen;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    op_code = 3'b000;
    matrix_size = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    seen = busy;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (process_Done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_start_idle got=%b exp=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    @(negedge clk);
    op_code = 3'b000;
    matrix_size = 2'b00;
    pixel_data = grid(8'd1, 5);
    kernel_data = grid(8'd1, 5);
    start = 1'b1;
    @(posedge clk);
    #1;
    lat1 = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (process_Done) begin
        lat1 = i;
        break;
      end
    end
    checks++;
    if (lat1 !== 5) begin
      failures++;
      $display("FAIL b2b_lat1 got=%0d exp=5", lat1);
    end
    checks++;
    if (result_final !== grid(8'd2, 2)) begin
      failures++;
      $display("FAIL b2b_res1 got=%h exp=%h", result_final, grid(8'd2, 2));
    end
    op_code = 3'b001;
    pixel_data = grid(8'd9, 5);
    kernel_data = grid(8'd4, 5);
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if ({busy, process_Done} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_reaccept got=%b%b exp=10", busy, process_Done);
    end
    lat2 = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (process_Done) begin
        lat2 = i;
        break;
      end
    end
    checks++;
    if (lat2 !== 5) begin
      failures++;
      $display("FAIL b2b_lat2 got=%0d exp=5", lat2);
    end
    checks++;
    if (result_final !== grid(8'd5, 2)) begin
      failures++;
      $display("FAIL b2b_res2 got=%h exp=%h", result_final, grid(8'd5, 2));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sat();
    test_mul();
    test_conv();
    test_reset_abort();
    test_transpose_reserved();
    test_start_ignored();
    test_reset_start_same();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_op_engine.md
# matrix_op_engine

Element-serial arithmetic engine that sits directly downstream of the HPS control unit's receive/process FSM. It accepts two 5×5 operand grids (unsigned pixel, signed kernel) as 200-bit flat buses plus an opcode and size, and computes one of six matrix operations with a single shared multiplier/accumulator. When finished it presents a saturated signed 8-bit 5×5 result grid and pulses `process_Done`, which the control unit captures before entering SENDING.

## Interface
- `clk` — the single clock; all state changes on rising edge.
- `reset` — input, 1 bit. Synchronous, active-high; see "Reset".
- `start` — input, 1 bit. Request a new operation; sampled only in IDLE.
- `op_code` — input, 3 bits. Operation select; latched with `start`.
- `matrix_size` — input, 2 bits. 00 = 2×2, 01 = 3×3, 10 = 4×4, 11 = 5×5. N = `matrix_size` + 2.
- `pixel_data` — input, 200 bits. Operand A: 25 unsigned bytes, element i at [8i+7:8i].
- `kernel_data` — input, 200 bits. Operand B: 25 signed bytes, same packing.
- `result_final` — output, 200 bits. Result: 25 signed bytes, same packing.
- `process_Done` — output, 1 bit. One-cycle completion pulse.
- `busy` — output, 1 bit. High from the `start` acceptance edge until `process_Done` deasserts.

## Operation
- Grid layout is row-major with a fixed stride of 5: element (r,c) is index 5r+c regardless of N.
  - Only r,c < N participate.
  - Every result element outside N×N is 0.
- Operand extension:
  - A is zero-extended to 9 bits.
  - B is sign-extended to 9 bits.
  - Accumulator is 21-bit signed.
- Every written result saturates to [-128, 127].
- Opcodes (R = result):
  - 000 ADD: R(r,c) = A(r,c) + B(r,c).
  - 001 SUB: R(r,c) = A(r,c) − B(r,c).
  - 010 MUL (matrix product): R(r,c) = Σk A(r,k)·B(k,c) for k = 0..N−1.
  - 011 TRANSPOSE: R(r,c) = A(c,r); B is ignored.
  - 100 SCALAR: R(r,c) = A(r,c)·B(0,0).
  - 101 CONV (single-point correlation): R(0,0) = Σ over all N×N of A(r,c)·B(r,c). All other R elements are 0.
  - 110, 111 (reserved): R = all zeros.
- FSM states: IDLE → COMPUTE → DONE → IDLE.
  - IDLE:
    - `start`=1 at an edge latches `op_code`, `matrix_size`, `pixel_data` and `kernel_data` into internal registers.
    - The same edge clears the internal result buffer and counters, sets `busy`=1 and moves to COMPUTE.
    - Input buses may change after the acceptance edge without effect.
  - COMPUTE:
    - Exactly one step per edge: one element for ADD/SUB/TRANSPOSE/SCALAR, one MAC for MUL/CONV.
    - Iteration order is row r outer, column c inner, and for MUL k innermost.
    - After the final step, move to DONE.
  - DONE:
    - Entry edge copies the buffer to `result_final` and sets `process_Done`=1.
    - Next edge clears `process_Done` and `busy` and returns to IDLE.
- `result_final` changes only on DONE entry. It holds its value through the following idle period and the next operation until the next DONE entry.
- `start` outside IDLE is ignored. If `start` is held high continuously, a new operation is accepted on the first edge in IDLE.

## Timing
- Step count C:
  - ADD, SUB, TRANSPOSE, SCALAR, CONV: C = N².
  - MUL: C = N³.
  - Reserved opcodes: C = 1.
- Let `start` be accepted at edge t0:
  - COMPUTE steps execute on edges t0+1 … t0+C.
  - `process_Done`=1 and `result_final` valid after edge t0+C+1.
  - `process_Done`=0 and `busy`=0 after edge t0+C+2.
  - Earliest next acceptance is edge t0+C+2, provided `start`=1 there.
- Extremes:
  - Minimum latency, 2×2 element op: done after t0+5.
  - Maximum latency, 5×5 MUL: done after t0+126.
- Reset:
  - Any edge with `reset`=1 forces IDLE.
  - It zeroes `result_final`, `process_Done`, `busy`, counters and latched operands.
  - This applies mid-COMPUTE and in DONE; the aborted operation never signals done.
  - `reset` has priority over `start` on the same edge.
- Reset value of every output is 0.

## Test plan
- **ADD 3×3.** Pixel all 10, kernel all 5.
  - Indices {0–2, 5–7, 10–12} = 15; all other bytes 0.
  - `process_Done` pulses for exactly one cycle after edge t0+10.
  - `busy` is high for t0 … t0+10.
- **SUB saturation, 2×2.** A/B pairs (200, −100), (0, 127), (0, −128), (5, 3).
  - R(0,0)=127, R(0,1)=−127, R(1,0)=127, R(1,1)=2.
- **MUL 2×2.** A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  - R = [[19,22],[43,50]] at indices 0, 1, 5, 6.
  - Done after edge t0+9.
  - Repeat 5×5 with A=identity, B[i]=i−12: R = B; done after edge t0+126.
- **CONV 5×5.**
  - Pixel all 255, kernel all 127 (sum 809625): R(0,0)=127.
  - Pixel all 1, kernel all −1: R(0,0)=−25; indices 1–24 are 0.
- **TRANSPOSE 4×4 plus reserved opcode.**
  - A(r,c) = 10r+c: R(r,c) = 10c+r.
  - Follow-up op 111: `result_final` = 0 after edge t0+2.
  - `result_final` is unchanged before that DONE entry.
- **Reset and start abuse.**
  - Start a 5×5 MUL, assert `reset` at step 20: all outputs 0 after that edge and no `process_Done` appears.
  - Pulse `start` during a second operation's COMPUTE: the pulse is ignored and latency stays C+1.
  - `reset` and `start` high on the same edge: the engine stays IDLE.
